// File: rtl/clock_divider.sv
// rtl/clock_divider.sv - programmable glitch-free clock divider and tick generator
module clock_divider #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,       // system clock, rising edge
    input  logic             reset,     // asynchronous, active-high
    input  logic             enable,    // run request
    input  logic [WIDTH-1:0] div,       // requested divide ratio
    input  logic             div_load,  // one-cycle strobe to request adoption of div
    input  logic             mode,      // 0 = square wave, 1 = pulse
    output logic             clk_out,   // divided clock
    output logic             tick,      // first cycle of every output period
    output logic             running,   // a period is in progress
    output logic             busy,      // validated ratio waiting for a boundary
    output logic             div_err    // div_load rejected (div < 2)
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ratio_q, ratio_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             busy_q, busy_d;
    logic             active_mode_q, active_mode_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             running_q, running_d;
    logic             div_err_q, div_err_d;

    logic             in_period;
    logic             last_cnt;
    logic             boundary;
    logic             load_ok;
    logic             sq_high;

    always_comb begin
        in_period = (state_q != IDLE);
        last_cnt  = (cnt_q == ratio_q - WIDTH'(1));
        // every IDLE cycle counts as a boundary so idle loads are adopted at once
        boundary  = !in_period || last_cnt;
        load_ok   = div_load && (div >= WIDTH'(2));
        // high for the first ceil(N/2) counts of the period
        sq_high   = (cnt_q < (ratio_q - (ratio_q >> 1)));

        state_d       = state_q;
        cnt_d         = cnt_q;
        ratio_d       = ratio_q;
        pending_d     = pending_q;
        busy_d        = busy_q;
        active_mode_d = active_mode_q;

        // adoption looks only at the registered pending value; a load arriving
        // on a boundary re-arms busy and waits for the next one
        if (boundary) begin
            active_mode_d = mode;
            if (busy_q) begin
                ratio_d = pending_q;
                busy_d  = 1'b0;
            end
        end
        if (load_ok) begin
            pending_d = div;
            busy_d    = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = last_cnt ? '0 : cnt_q + WIDTH'(1);
                if (!enable) begin
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                if (last_cnt) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // outputs describe the current count and appear one edge later
        running_d = in_period;
        tick_d    = in_period && (cnt_q == '0);
        clk_out_d = in_period && (active_mode_q ? (cnt_q == '0) : sq_high);
        div_err_d = div_load && !load_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ratio_q       <= WIDTH'(DEFAULT_DIV);
            pending_q     <= WIDTH'(DEFAULT_DIV);
            busy_q        <= 1'b0;
            active_mode_q <= 1'b0;
            clk_out_q     <= 1'b0;
            tick_q        <= 1'b0;
            running_q     <= 1'b0;
            div_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ratio_q       <= ratio_d;
            pending_q     <= pending_d;
            busy_q        <= busy_d;
            active_mode_q <= active_mode_d;
            clk_out_q     <= clk_out_d;
            tick_q        <= tick_d;
            running_q     <= running_d;
            div_err_q     <= div_err_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign running = running_q;
    assign busy    = busy_q;
    assign div_err = div_err_q;

endmodule

// File: tb/tb_clock_divider.sv
// tb/tb_clock_divider.sv - self-checking bench for clock_divider
module tb_clock_divider;

    localparam int W = 8;

    logic         clk      = 1'b0;
    logic         reset    = 1'b0;
    logic         enable   = 1'b0;
    logic         div_load = 1'b0;
    logic         mode     = 1'b0;
    logic [W-1:0] div      = '0;
    logic         clk_out, tick, running, busy, div_err;

    int n_checks = 0;
    int n_errors = 0;

    clock_divider #(.WIDTH(W), .DEFAULT_DIV(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .div      (div),
        .div_load (div_load),
        .mode     (mode),
        .clk_out  (clk_out),
        .tick     (tick),
        .running  (running),
        .busy     (busy),
        .div_err  (div_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit en;
        bit ld;
        int d;
        bit md;
        bit e_clk;
        bit e_tick;
        bit e_run;
        bit e_busy;
        bit e_err;
    } vec_t;

    vec_t tbl[32];

    // reference model: whole output periods, not a counter
    int m_left;   // cycles of the current period still to come, 0 = idle
    int m_len;    // length of the current period
    int m_mode;   // mode of the current period
    int m_stop;   // current period is the last one
    int m_ratio;
    int m_pend;
    int m_busy;

    function automatic vec_t v(bit en, bit ld, int d, bit md,
                               bit c, bit t, bit r, bit b, bit e);
        vec_t x;
        x.en = en; x.ld = ld; x.d = d; x.md = md;
        x.e_clk = c; x.e_tick = t; x.e_run = r; x.e_busy = b; x.e_err = e;
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_left = 0; m_len = 0; m_mode = 0; m_stop = 0;
        m_ratio = 2; m_pend = 2; m_busy = 0;
    endtask

    task automatic model_step(input bit en, input bit ld, input int d, input bit md);
        bit at_boundary;
        at_boundary = (m_left <= 1);
        if (at_boundary && m_busy != 0) begin
            m_ratio = m_pend;
            m_busy  = 0;
        end
        if (ld && d >= 2) begin
            m_pend = d;
            m_busy = 1;
        end
        if (m_left == 0) begin
            if (en) begin
                m_len = m_ratio; m_left = m_ratio; m_mode = md; m_stop = 0;
            end
        end else if (m_left == 1) begin
            if (m_stop != 0) begin
                m_left = 0; m_stop = 0;
            end else begin
                m_len = m_ratio; m_left = m_ratio; m_mode = md; m_stop = en ? 0 : 1;
            end
        end else begin
            m_left--;
            if (!en) m_stop = 1;
        end
    endtask

    // called at a falling edge; returns at the next falling edge
    task automatic cycle(input bit en, input bit ld, input int d, input bit md, input string tag);
        int i;
        bit e_clk, e_tick, e_run, e_err;
        enable = en; div_load = ld; div = W'(d); mode = md;
        e_clk = 0; e_tick = 0; e_run = 0;
        if (m_left != 0) begin
            i      = m_len - m_left;
            e_tick = (i == 0);
            e_clk  = (m_mode != 0) ? (i == 0) : (i < (m_len + 1) / 2);
            e_run  = 1;
        end
        e_err = ld && (d < 2);
        model_step(en, ld, d, md);
        @(posedge clk);
        @(negedge clk);
        chk({tag, " clk_out"}, clk_out, e_clk);
        chk({tag, " tick"},    tick,    e_tick);
        chk({tag, " running"}, running, e_run);
        chk({tag, " busy"},    busy,    m_busy);
        chk({tag, " div_err"}, div_err, e_err);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1 (simulation did not complete)");
        $fatal(1);
    end

    initial begin
        bit ticks[14];
        bit clks[14];
        int t1, t2, highs;

        tbl[0]  = v(1,0,0,0, 0,0,0,0,0);
        tbl[1]  = v(1,0,0,0, 1,1,1,0,0);
        tbl[2]  = v(1,0,0,0, 0,0,1,0,0);
        tbl[3]  = v(1,1,1,0, 1,1,1,0,1);
        tbl[4]  = v(1,1,0,0, 0,0,1,0,1);
        tbl[5]  = v(1,0,0,0, 1,1,1,0,0);
        tbl[6]  = v(1,1,5,0, 0,0,1,1,0);
        tbl[7]  = v(1,0,0,0, 1,1,1,1,0);
        tbl[8]  = v(1,0,0,0, 0,0,1,0,0);
        tbl[9]  = v(1,0,0,0, 1,1,1,0,0);
        tbl[10] = v(1,0,0,0, 1,0,1,0,0);
        tbl[11] = v(1,0,0,0, 1,0,1,0,0);
        tbl[12] = v(1,0,0,0, 0,0,1,0,0);
        tbl[13] = v(1,0,0,0, 0,0,1,0,0);
        tbl[14] = v(1,0,0,0, 1,1,1,0,0);
        tbl[15] = v(0,0,0,0, 1,0,1,0,0);
        tbl[16] = v(1,0,0,0, 1,0,1,0,0);
        tbl[17] = v(0,0,0,0, 0,0,1,0,0);
        tbl[18] = v(1,0,0,0, 0,0,1,0,0);
        tbl[19] = v(1,0,0,0, 0,0,0,0,0);
        tbl[20] = v(1,0,0,0, 1,1,1,0,0);
        tbl[21] = v(1,1,4,1, 1,0,1,1,0);
        tbl[22] = v(1,0,0,1, 1,0,1,1,0);
        tbl[23] = v(1,0,0,1, 0,0,1,1,0);
        tbl[24] = v(1,0,0,1, 0,0,1,0,0);
        tbl[25] = v(1,0,0,1, 1,1,1,0,0);
        tbl[26] = v(1,0,0,0, 0,0,1,0,0);
        tbl[27] = v(1,0,0,0, 0,0,1,0,0);
        tbl[28] = v(1,0,0,0, 0,0,1,0,0);
        tbl[29] = v(1,0,0,0, 1,1,1,0,0);
        tbl[30] = v(1,0,0,0, 1,0,1,0,0);
        tbl[31] = v(1,0,0,0, 0,0,1,0,0);

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset clk_out", clk_out, 0);
        chk("reset tick",    tick,    0);
        chk("reset running", running, 0);
        chk("reset busy",    busy,    0);
        chk("reset div_err", div_err, 0);
        reset = 1'b0;

        for (int r = 0; r < 32; r++) begin
            enable = tbl[r].en; div_load = tbl[r].ld; div = W'(tbl[r].d); mode = tbl[r].md;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d clk_out", r), clk_out, tbl[r].e_clk);
            chk($sformatf("vec%0d tick", r),    tick,    tbl[r].e_tick);
            chk($sformatf("vec%0d running", r), running, tbl[r].e_run);
            chk($sformatf("vec%0d busy", r),    busy,    tbl[r].e_busy);
            chk($sformatf("vec%0d div_err", r), div_err, tbl[r].e_err);
        end

        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        cycle(0, 1, 5, 0, "idle_load");
        cycle(0, 0, 0, 0, "idle_adopt");
        repeat (7) cycle(1, 0, 0, 0, "run5");
        cycle(1, 1, 7, 0, "run5_load");
        #2 reset = 1'b1;
        #1;
        chk("async clk_out", clk_out, 0);
        chk("async tick",    tick,    0);
        chk("async running", running, 0);
        chk("async busy",    busy,    0);
        chk("async div_err", div_err, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        cycle(0, 1, 5, 0, "reload5");
        cycle(0, 0, 0, 0, "reload5_adopt");
        for (int k = 0; k < 14; k++) begin
            cycle(1, 0, 0, 0, "restart");
            ticks[k] = tick;
            clks[k]  = clk_out;
        end
        t1 = -1; t2 = -1;
        for (int k = 0; k < 14; k++) begin
            if (ticks[k]) begin
                if (t1 < 0) t1 = k;
                else if (t2 < 0) t2 = k;
            end
        end
        chk("start latency first tick", t1, 1);
        chk("period after reset", t2 - t1, 5);
        highs = 0;
        for (int k = 1; k < 6; k++) highs += clks[k];
        chk("high cycles after reset", highs, 3);

        for (int n = 0; n < 1500; n++) begin
            cycle($urandom_range(0, 9) != 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 12),
                  $urandom_range(0, 5) == 0,
                  "rand");
        end
        div_load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clock_divider.md
# clock_divider

Parametrised, glitch-free clock-enable/divider generator for the single-cycle and pipelined CPU test harnesses. Derives a divided square wave or a one-cycle tick from the system clock. The divide ratio is programmable at run time and changes only on period boundaries. Enable-driven start/stop always completes the current period, so no output runt pulses are produced.

## Interface
- WIDTH, 8, bit width of divide ratio and internal counter; legal ratios 2 .. 2^WIDTH-1
- DEFAULT_DIV, 2, ratio in force after reset; must be ≥2 and fit in WIDTH
- clk  input  1  system clock, all flops on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- enable  input  1  run request
- div  input  WIDTH  requested divide ratio
- div_load  input  1  one-cycle strobe to request adoption of div
- mode  input  1  0 = square wave, 1 = pulse (clk_out equals tick)
- clk_out  output  1  divided clock, registered
- tick  output  1  high for first cycle of every output period, registered
- running  output  1  high in RUN and STOPPING
- busy  output  1  a validated ratio is pending, not yet adopted
- div_err  output  1  one-cycle pulse: div_load rejected (div < 2)

## Operation
- Registers: state {IDLE, RUN, STOPPING}, cnt[WIDTH], ratio[WIDTH], pending[WIDTH], busy, active_mode.
- Reset values: state IDLE, cnt 0, ratio DEFAULT_DIV, active_mode 0, clk_out 0, tick 0, running 0, busy 0, div_err 0.
- Period boundary: the cycle in RUN/STOPPING where cnt == ratio-1, or any IDLE cycle.
- IDLE: cnt held 0, all outputs 0. enable sampled 1 → RUN with cnt = 0; ratio and mode adopted on that transition.
- RUN: cnt increments each cycle and wraps from ratio-1 to 0. At each wrap, pending ratio (if busy) and mode are adopted. enable sampled 0 → STOPPING (cnt continues).
- STOPPING: enable ignored. Current period runs to cnt == ratio-1, then → IDLE. Minimum one IDLE cycle always follows a stop.
- Square mode: clk_out = 1 while cnt < ratio - floor(ratio/2), else 0. High ceil(N/2) cycles, low floor(N/2) cycles.
- Pulse mode: clk_out = tick.
- tick = 1 in the cycle where cnt == 0 and state is RUN/STOPPING.
- Ratio load, div ≥ 2: pending ← div, busy ← 1. A load while busy overwrites pending (last wins).
- Ratio load, div < 2: ignored. div_err pulses 1, and pending/busy are unchanged.
- Adoption uses the registered pending value only. A div_load in the same cycle as a boundary takes effect at the following boundary. busy clears in the cycle the new ratio first governs cnt.
- Arithmetic: cnt compare/increment is unsigned WIDTH-bit. cnt never exceeds ratio-1, so no overflow is possible.

## Timing
- All outputs are flop outputs; no combinational path from inputs to outputs.
- Start latency: enable sampled high at edge k in IDLE → running, tick, and clk_out (square mode) all 1 during the cycle after edge k+1.
- Output period is exactly ratio clk cycles. No partial periods except those forced by reset.
- Stop: final period is full length. running falls together with clk_out/tick returning to idle 0.
- Idle ratio load: busy rises one cycle after div_load, then clears one cycle later (IDLE is a boundary).
- Reset asserted mid-period: outputs go to reset values asynchronously, without waiting for clk. The first period after reset release is normal, with no runt.
- enable toggling within a single period in STOPPING has no effect.

## Test plan
- Reset mid-run: divider running at ratio 5, assert reset between clk edges → clk_out, tick, running, busy drop to 0 before the next edge; after release plus enable, the first period is 5 cycles.
- Default run: DEFAULT_DIV=2, enable=1 → clk_out 1,0,1,0…; tick every 2nd cycle, coincident with clk_out high.
- Live reload: running at 2, div_load div=5 → busy=1 until next wrap; then periods of 5 cycles (3 high, 2 low) and busy=0.
- Graceful stop/restart: ratio 5, enable dropped at cnt=1 → 3 further cycles complete the period, then running=0. enable held high → restart after exactly 1 IDLE cycle.
- Rejected load: div_load div=1 (also div=0) → div_err one-cycle pulse, busy stays 0, period length unchanged.
- Pulse mode: mode=1, div=4 loaded → clk_out is a single-cycle high every 4 cycles, identical to tick; mode switch back to 0 takes effect only at the next wrap.
